mms_stream: RTL and testbench

- Streaming max/min selector. Accepts a frame of FRAME_LEN unsigned samples, one per accepted beat, over a valid/ready input port.
- Returns the frame maximum (select=0) or minimum (select=1) on a valid/ready output port.
- Sequential, parametrised successor to the fixed 4-input combinational max/min tree. Sits between a sample source and downstream logic in the SV project datapath.

---
 rtl/mms_stream.sv | 141 ++++++++++++++
 tb/tb_mms_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mms_stream.sv
// mms_stream: streaming frame max/min selector on valid/ready ports.
// Define MMS_STREAM_INDEX_EN to add result_idx (winning beat position).
module mms_stream #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 4,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] number,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MMS_STREAM_INDEX_EN
  output logic [CNT_W-1:0] result_idx,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ov_q, ov_d;
`ifdef MMS_STREAM_INDEX_EN
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ridx_q, ridx_d;
`endif

  logic             take;
  logic             better;
  logic [WIDTH-1:0] nxt_acc;

  assign in_ready  = (state_q != DONE);
  assign out_valid = ov_q;
  assign result    = res_q;
`ifdef MMS_STREAM_INDEX_EN
  assign result_idx = ridx_q;
`endif

  assign take    = in_valid && in_ready;
  // Strict compare: ties keep the earlier sample.
  assign better  = mode_q ? (number < acc_q) : (number > acc_q);
  assign nxt_acc = better ? number : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    res_d   = res_q;
    ov_d    = ov_q;
`ifdef MMS_STREAM_INDEX_EN
    idx_d   = idx_q;
    ridx_d  = ridx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          cnt_d = '0;
        end else if (take) begin
          acc_d   = number;
          mode_d  = select;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
`ifdef MMS_STREAM_INDEX_EN
          idx_d   = '0;
`endif
        end
      end
      ACCUM: begin
        if (clear) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (take) begin
          acc_d = nxt_acc;
`ifdef MMS_STREAM_INDEX_EN
          if (better) idx_d = cnt_q;
`endif
          if (cnt_q == LAST) begin
            state_d = DONE;
            ov_d    = 1'b1;
            res_d   = nxt_acc;
            cnt_d   = '0;
`ifdef MMS_STREAM_INDEX_EN
            ridx_d  = better ? cnt_q : idx_q;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      ov_q    <= 1'b0;
`ifdef MMS_STREAM_INDEX_EN
      idx_q   <= '0;
      ridx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
`ifdef MMS_STREAM_INDEX_EN
      idx_q   <= idx_d;
      ridx_q  <= ridx_d;
`endif
    end
  end

endmodule

// File: tb/tb_mms_stream.sv
// tb_mms_stream: directed vectors for mms_stream, 8-bit/4 and 16-bit/5.
// Index checks are active when MMS_STREAM_INDEX_EN is defined.
module tb_mms_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_iv = 0, a_sel = 0, a_clr = 0, a_ordy = 1;
  logic [7:0] a_num = 0;
  logic       a_irdy, a_ov;
  logic [7:0] a_res;
  logic       b_iv = 0, b_sel = 0, b_clr = 0, b_ordy = 1;
  logic [15:0] b_num = 0;
  logic        b_irdy, b_ov;
  logic [15:0] b_res;
`ifdef MMS_STREAM_INDEX_EN
  logic [1:0] a_idx;
  logic [2:0] b_idx;
`endif

  mms_stream u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_iv), .in_ready(a_irdy),
    .select(a_sel), .number(a_num),
    .clear(a_clr), .out_valid(a_ov),
    .out_ready(a_ordy),
`ifdef MMS_STREAM_INDEX_EN
    .result_idx(a_idx),
`endif
    .result(a_res)
  );

  mms_stream #(.WIDTH(16), .FRAME_LEN(5)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_iv), .in_ready(b_irdy),
    .select(b_sel), .number(b_num),
    .clear(b_clr), .out_valid(b_ov),
    .out_ready(b_ordy),
`ifdef MMS_STREAM_INDEX_EN
    .result_idx(b_idx),
`endif
    .result(b_res)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v, input logic s);
    a_iv = 1; a_num = v; a_sel = s;
    tick();
    a_iv = 0;
  endtask

  task automatic beat_b(input logic [15:0] v, input logic s);
    b_iv = 1; b_num = v; b_sel = s;
    tick();
    b_iv = 0;
  endtask

  task automatic done_a(input string tag,
                        input logic [7:0] exp,
                        input int eidx);
    chk({tag, ".ov"}, 32'(a_ov), 1);
    chk({tag, ".res"}, 32'(a_res), 32'(exp));
    chk({tag, ".irdy"}, 32'(a_irdy), 0);
`ifdef MMS_STREAM_INDEX_EN
    chk({tag, ".idx"}, 32'(a_idx), 32'(eidx));
`else
    if (eidx < 0) chk({tag, ".eidx"}, 32'(eidx), 0);
`endif
  endtask

  task automatic handoff_a(input string tag);
    a_ordy = 1;
    tick();
    chk({tag, ".ov0"}, 32'(a_ov), 0);
    chk({tag, ".irdy1"}, 32'(a_irdy), 1);
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst.a.irdy", 32'(a_irdy), 1);
    chk("rst.a.ov", 32'(a_ov), 0);
    chk("rst.a.res", 32'(a_res), 0);
    chk("rst.b.irdy", 32'(b_irdy), 1);
    chk("rst.b.ov", 32'(b_ov), 0);

    // back-to-back max, duplicate 200 keeps beat 1
    beat(8'd3, 0); beat(8'd200, 0);
    beat(8'd17, 0);
    chk("t1.early", 32'(a_ov), 0);
    beat(8'd200, 0);
    done_a("t1", 8'd200, 1);
    handoff_a("t1");

    // min with two bubbles
    beat(8'd90, 1); beat(8'd12, 1);
    tick(); tick();
    chk("t2.bub", 32'(a_ov), 0);
    beat(8'd255, 1);
    chk("t2.early", 32'(a_ov), 0);
    beat(8'd0, 1);
    done_a("t2", 8'd0, 3);
    handoff_a("t2");

    // select latched on first beat
    beat(8'd5, 0); beat(8'd9, 1);
    beat(8'd1, 1); beat(8'd7, 1);
    done_a("t3", 8'd9, 1);
    handoff_a("t3");

    // backpressure; clear in DONE is ignored
    a_ordy = 0;
    beat(8'd42, 0); beat(8'd10, 0);
    beat(8'd20, 0); beat(8'd30, 0);
    a_iv = 1; a_num = 8'd255;
    for (int i = 0; i < 5; i++) begin
      a_clr = (i == 2);
      tick();
      done_a("t4.hold", 8'd42, 0);
    end
    a_clr = 0; a_iv = 0;
    handoff_a("t4");

    // clear drops partial frame and the beat shown with it
    beat(8'd50, 0); beat(8'd60, 0);
    a_clr = 1; a_iv = 1; a_num = 8'd99;
    tick();
    a_clr = 0; a_iv = 0;
    chk("t5.clr.irdy", 32'(a_irdy), 1);
    chk("t5.clr.ov", 32'(a_ov), 0);
    beat(8'd1, 0); beat(8'd2, 0);
    beat(8'd3, 0);
    chk("t5.early", 32'(a_ov), 0);
    beat(8'd4, 0);
    done_a("t5", 8'd4, 3);
    handoff_a("t5");

    // mid-frame reset
    beat(8'd7, 0); beat(8'd8, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t5.rst.ov", 32'(a_ov), 0);
    chk("t5.rst.irdy", 32'(a_irdy), 1);
    chk("t5.rst.res", 32'(a_res), 0);

    // fresh frame after reset, tie on min
    beat(8'd6, 1); beat(8'd6, 1);
    beat(8'd2, 1); beat(8'd2, 1);
    done_a("t6", 8'd2, 2);
    handoff_a("t6");

    // reset while holding a result
    a_ordy = 0;
    beat(8'd11, 0); beat(8'd22, 0);
    beat(8'd33, 0); beat(8'd44, 0);
    done_a("t7", 8'd44, 3);
    reset = 1;
    tick();
    reset = 0;
    chk("t7.rst.ov", 32'(a_ov), 0);
    chk("t7.rst.irdy", 32'(a_irdy), 1);
    a_ordy = 1;

    // 16-bit, 5-beat min with tie
    beat_b(16'hFFFF, 1); beat_b(16'h8000, 1);
    beat_b(16'h8000, 1); beat_b(16'hFFFE, 1);
    chk("t8.early", 32'(b_ov), 0);
    beat_b(16'h9000, 1);
    chk("t8.ov", 32'(b_ov), 1);
    chk("t8.res", 32'(b_res), 32'h8000);
    chk("t8.irdy", 32'(b_irdy), 0);
`ifdef MMS_STREAM_INDEX_EN
    chk("t8.idx", 32'(b_idx), 1);
`endif
    tick();
    chk("t8.ov0", 32'(b_ov), 0);
    chk("t8.irdy1", 32'(b_irdy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
